// File: rtl/nora_mem_pkg.sv
// Shared definitions for the SRAM arbiter and its strobe sequencer:
// sequencer state encoding, access owner encoding and SRAM address width.
package nora_mem_pkg;

  localparam int SRAM_ADDR_W = 21;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } seq_state_e;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_ICD = 1'b1
  } owner_e;

endpackage

// File: rtl/sram_strobe_seq.sv
// SETUP -> STROBE -> HOLD sequencer for one SRAM access. All strobes and the
// done pulse are registered from the next state, so the pins never glitch.
module sram_strobe_seq
  import nora_mem_pkg::*;
#(
  parameter int STROBE_CYCLES = 2
) (
  input  logic       clk6x,
  input  logic       resetn,
  input  logic       start,
  input  logic       start_rwn,
  output logic [1:0] state_o,
  output logic       rd_sample,
  output logic       done,
  output logic       m1csn,
  output logic       mrdn,
  output logic       mwrn,
  output logic       mem_oe
);

  localparam logic [1:0] CNT_INIT = 2'(STROBE_CYCLES - 1);

  seq_state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       rwn_q, rwn_d;
  logic       m1csn_q, m1csn_d, mrdn_q, mrdn_d, mwrn_q, mwrn_d;
  logic       oe_q, oe_d, done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rwn_d   = rwn_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          rwn_d   = start_rwn;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = CNT_INIT;
      end
      ST_STROBE: begin
        if (cnt_q == 2'd0) state_d = ST_HOLD;
        else               cnt_d   = cnt_q - 2'd1;
      end
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // mrdn only in SETUP/STROBE of reads, mwrn only in STROBE of writes:
    // the two can never be low together.
    m1csn_d = (state_d == ST_IDLE);
    mrdn_d  = !(rwn_d && (state_d == ST_SETUP || state_d == ST_STROBE));
    mwrn_d  = !(!rwn_d && state_d == ST_STROBE);
    oe_d    = !rwn_d && (state_d != ST_IDLE);
    done_d  = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      rwn_q   <= 1'b1;
      m1csn_q <= 1'b1;
      mrdn_q  <= 1'b1;
      mwrn_q  <= 1'b1;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rwn_q   <= rwn_d;
      m1csn_q <= m1csn_d;
      mrdn_q  <= mrdn_d;
      mwrn_q  <= mwrn_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
    end
  end

  assign state_o   = state_q;
  assign rd_sample = (state_q == ST_STROBE) && (cnt_q == 2'd0) && rwn_q;
  assign done      = done_q;
  assign m1csn     = m1csn_q;
  assign mrdn      = mrdn_q;
  assign mwrn      = mwrn_q;
  assign mem_oe    = oe_q;

endmodule

// File: rtl/sram_arbiter.sv
// SRAM owner: fixed-priority CPU port plus req/ack ICD debug master.
// Define SRAM_ARB_STATS_EN to add saturating icd/collide counters.
module sram_arbiter
  import nora_mem_pkg::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int ADDR_W        = SRAM_ADDR_W
) (
  input  logic              clk6x,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_rwn,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_done,
  input  logic              cpu_window,
  input  logic              icd_req,
  input  logic              icd_rwn,
  input  logic [ADDR_W-1:0] icd_addr,
  input  logic [7:0]        icd_wdata,
  output logic [7:0]        icd_rdata,
  output logic              icd_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_oe,
  input  logic [7:0]        mem_rdata,
  output logic              m1csn,
  output logic              mrdn,
  output logic              mwrn,
  output logic              collide
`ifdef SRAM_ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       icd_count,
  output logic [15:0]       collide_count
`endif
);

  logic [1:0]        seq_state;
  logic              seq_idle, seq_done, rd_sample;
  logic              grant_cpu, grant_icd, rwn_sel;
  owner_e            owner_q, owner_d;
  logic              pend_q, pend_d, collide_q, collide_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d, icd_rdata_q, icd_rdata_d;

  assign seq_idle = (seq_state == ST_IDLE);

  always_comb begin
    grant_cpu   = seq_idle && (cpu_req || pend_q);
    grant_icd   = seq_idle && !grant_cpu && icd_req && !cpu_window;
    owner_d     = owner_q;
    pend_d      = pend_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rwn_sel     = 1'b1;
    collide_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    icd_rdata_d = icd_rdata_q;

    if (grant_cpu) begin
      owner_d = OWNER_CPU;
      pend_d  = 1'b0;
      addr_d  = cpu_addr;
      wdata_d = cpu_wdata;
      rwn_sel = cpu_rwn;
    end else if (grant_icd) begin
      owner_d = OWNER_ICD;
      addr_d  = icd_addr;
      wdata_d = icd_wdata;
      rwn_sel = icd_rwn;
    end else if (!seq_idle && cpu_req && !pend_q) begin
      // CPU request during a busy access is parked; a repeat while parked is dropped.
      pend_d    = 1'b1;
      collide_d = (owner_q == OWNER_ICD);
    end

    if (rd_sample) begin
      if (owner_q == OWNER_CPU) cpu_rdata_d = mem_rdata;
      else                      icd_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      owner_q     <= OWNER_CPU;
      pend_q      <= 1'b0;
      collide_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      icd_rdata_q <= '0;
    end else begin
      owner_q     <= owner_d;
      pend_q      <= pend_d;
      collide_q   <= collide_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      icd_rdata_q <= icd_rdata_d;
    end
  end

  sram_strobe_seq #(
    .STROBE_CYCLES(STROBE_CYCLES)
  ) u_seq (
    .clk6x    (clk6x),
    .resetn   (resetn),
    .start    (grant_cpu || grant_icd),
    .start_rwn(rwn_sel),
    .state_o  (seq_state),
    .rd_sample(rd_sample),
    .done     (seq_done),
    .m1csn    (m1csn),
    .mrdn     (mrdn),
    .mwrn     (mwrn),
    .mem_oe   (mem_oe)
  );

  assign cpu_done  = seq_done && (owner_q == OWNER_CPU);
  assign icd_ack   = seq_done && (owner_q == OWNER_ICD);
  assign collide   = collide_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign icd_rdata = icd_rdata_q;

  a_single_pending: assert property (@(posedge clk6x) disable iff (!resetn)
    !(cpu_req && pend_q));

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] icd_cnt_q, icd_cnt_d, col_cnt_q, col_cnt_d;

  always_comb begin
    icd_cnt_d = icd_cnt_q;
    col_cnt_d = col_cnt_q;
    if (stats_clr) begin
      icd_cnt_d = '0;
      col_cnt_d = '0;
    end else begin
      if (icd_ack && icd_cnt_q != 16'hFFFF)   icd_cnt_d = icd_cnt_q + 16'd1;
      if (collide_q && col_cnt_q != 16'hFFFF) col_cnt_d = col_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      icd_cnt_q <= '0;
      col_cnt_q <= '0;
    end else begin
      icd_cnt_q <= icd_cnt_d;
      col_cnt_q <= col_cnt_d;
    end
  end

  assign icd_count     = icd_cnt_q;
  assign collide_count = col_cnt_q;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: cycle-offset access model checked every
// cycle, behavioural SRAM on the pins, and literal checks per scenario.
module tb_sram_arbiter;

  localparam int S = 2;

  logic        clk6x, resetn;
  logic        cpu_req, cpu_rwn, cpu_window, cpu_done;
  logic [20:0] cpu_addr, icd_addr, mem_addr;
  logic [7:0]  cpu_wdata, cpu_rdata, icd_wdata, icd_rdata, mem_wdata, mem_rdata;
  logic        icd_req, icd_rwn, icd_ack, mem_oe, m1csn, mrdn, mwrn, collide;
`ifdef SRAM_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] icd_count, collide_count;
`endif

  int tests = 0;
  int failed = 0;

  sram_arbiter #(.STROBE_CYCLES(S), .ADDR_W(21)) dut (
    .clk6x(clk6x), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_rwn(cpu_rwn), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_window(cpu_window),
    .icd_req(icd_req), .icd_rwn(icd_rwn), .icd_addr(icd_addr), .icd_wdata(icd_wdata),
    .icd_rdata(icd_rdata), .icd_ack(icd_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_oe(mem_oe), .mem_rdata(mem_rdata),
    .m1csn(m1csn), .mrdn(mrdn), .mwrn(mwrn), .collide(collide)
`ifdef SRAM_ARB_STATS_EN
    , .stats_clr(stats_clr), .icd_count(icd_count), .collide_count(collide_count)
`endif
  );

  // ---------------- clock ----------------
  initial clk6x = 1'b0;
  always #5 clk6x = ~clk6x;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural SRAM on the pins ----------------
  logic [7:0] sram [int];
  function automatic logic [7:0] dflt(input logic [20:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(negedge clk6x) begin
    if (!m1csn && !mwrn) sram[int'(mem_addr)] = mem_wdata;
    mem_rdata = sram.exists(int'(mem_addr)) ? sram[int'(mem_addr)] : dflt(mem_addr);
  end

  // ---------------- access model ----------------
  // Each access is a grant cycle g: g+1 SETUP, g+2..g+1+S STROBE, g+2+S HOLD.
  int          cyc = 0;
  bit          chk_en = 0;
  bit          act_valid = 0, act_icd = 0, act_rwn = 1;
  logic [20:0] act_addr = '0;
  int          act_g = 0;
  bit          pend = 0;
  logic        p_rwn = 1'b1;
  logic [20:0] p_addr = '0;
  logic [7:0]  p_wdata = '0;
  logic [20:0] e_addr = '0;
  logic [7:0]  e_wdata = '0, e_crd = '0, e_ird = '0;
  bit          e_col = 0;
  logic [7:0]  mm [int];

  function automatic logic [7:0] mm_rd(input logic [20:0] a);
    return mm.exists(int'(a)) ? mm[int'(a)] : dflt(a);
  endfunction

  task automatic m_grant(input bit icd, input logic rwn, input logic [20:0] a, input logic [7:0] d);
    act_valid = 1; act_icd = icd; act_rwn = rwn; act_addr = a; act_g = cyc;
    e_addr = a; e_wdata = d;
    if (!rwn) mm[int'(a)] = d;
  endtask

  always @(negedge clk6x) begin : model
    int ph;
    bit busy;
    busy = 0;
    ph = 0;
    if (act_valid) begin
      ph = cyc - act_g;
      if (ph >= 3 + S) act_valid = 0;
      else busy = 1;
    end
    if (chk_en) begin
      if (busy && ph == 2 + S && act_rwn) begin
        if (act_icd) e_ird = mm_rd(act_addr);
        else         e_crd = mm_rd(act_addr);
      end
      check("m_m1csn",  32'(m1csn),  32'(!busy));
      check("m_mrdn",   32'(mrdn),   32'(!(busy && act_rwn && ph <= 1 + S)));
      check("m_mwrn",   32'(mwrn),   32'(!(busy && !act_rwn && ph >= 2 && ph <= 1 + S)));
      check("m_mem_oe", 32'(mem_oe), 32'(busy && !act_rwn));
      check("m_cpu_done", 32'(cpu_done), 32'(busy && ph == 2 + S && !act_icd));
      check("m_icd_ack",  32'(icd_ack),  32'(busy && ph == 2 + S && act_icd));
      check("m_collide",  32'(collide),  32'(e_col));
      check("m_mem_addr", 32'(mem_addr), 32'(e_addr));
      check("m_mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      check("m_cpu_rdata", 32'(cpu_rdata), 32'(e_crd));
      check("m_icd_rdata", 32'(icd_rdata), 32'(e_ird));
    end
    if (!resetn) begin
      act_valid = 0; pend = 0; e_col = 0;
      e_addr = '0; e_wdata = '0; e_crd = '0; e_ird = '0;
      chk_en = 1;
    end else if (chk_en) begin
      e_col = 0;
      if (!busy) begin
        if (pend) begin
          m_grant(0, p_rwn, p_addr, p_wdata);
          pend = 0;
        end else if (cpu_req) m_grant(0, cpu_rwn, cpu_addr, cpu_wdata);
        else if (icd_req && !cpu_window) m_grant(1, icd_rwn, icd_addr, icd_wdata);
      end else if (cpu_req && !pend) begin
        pend = 1; p_rwn = cpu_rwn; p_addr = cpu_addr; p_wdata = cpu_wdata;
        e_col = act_icd;
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic cpu_access(input logic rwn, input logic [20:0] a, input logic [7:0] d,
                            output int lat, output int wl, output int oe);
    cpu_rwn = rwn; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    lat = -1; wl = 0; oe = 0;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(negedge clk6x);
      if (!mwrn) wl++;
      if (mem_oe) oe++;
      if (cpu_done) lat = k;
      @(posedge clk6x); #1;
      cpu_req = 1'b0;
    end
  endtask

  task automatic icd_access(input logic rwn, input logic [20:0] a, input logic [7:0] d,
                            output int lat, output int acks, output int bad_addr);
    icd_rwn = rwn; icd_addr = a; icd_wdata = d; icd_req = 1'b1;
    lat = -1; acks = 0; bad_addr = 0;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(negedge clk6x);
      if (!m1csn && mem_addr != a) bad_addr++;
      if (icd_ack) begin lat = k; acks++; end
      @(posedge clk6x); #1;
      if (lat >= 0) icd_req = 1'b0;
    end
    repeat (3) begin
      @(negedge clk6x);
      if (icd_ack) acks++;
      @(posedge clk6x); #1;
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int lat, wl, oe, acks, bad, dk, dk2, ak, col, colk, cs_first, cs_win, dn;
    resetn = 1'b0; cpu_req = 1'b0; cpu_rwn = 1'b1; cpu_addr = '0; cpu_wdata = '0;
    cpu_window = 1'b0; icd_req = 1'b0; icd_rwn = 1'b1; icd_addr = '0; icd_wdata = '0;
`ifdef SRAM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) @(posedge clk6x);
    #1 resetn = 1'b1;

    @(negedge clk6x);
    check("rst_m1csn", 32'(m1csn), 32'd1);
    check("rst_mrdn", 32'(mrdn), 32'd1);
    check("rst_mwrn", 32'(mwrn), 32'd1);
    check("rst_mem_oe", 32'(mem_oe), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    @(posedge clk6x); #1;

    // CPU write 0x10 <- 0x12 then read back
    cpu_access(1'b0, 21'h00010, 8'h12, lat, wl, oe);
    check("cpu_wr_latency", 32'(lat), 32'd4);
    check("cpu_wr_mwrn_low_cycles", 32'(wl), 32'd2);
    check("cpu_wr_oe_cycles", 32'(oe), 32'd4);
    cpu_access(1'b1, 21'h00010, 8'h00, lat, wl, oe);
    check("cpu_rd_latency", 32'(lat), 32'd4);
    check("cpu_rd_mwrn_low_cycles", 32'(wl), 32'd0);
    check("cpu_rd_data", 32'(cpu_rdata), 32'h12);

    // ICD write 0x1F000 <- 0xA5 then read back
    icd_access(1'b0, 21'h1F000, 8'hA5, lat, acks, bad);
    check("icd_wr_latency", 32'(lat), 32'd4);
    check("icd_wr_acks", 32'(acks), 32'd1);
    check("icd_wr_addr_stable", 32'(bad), 32'd0);
    icd_access(1'b1, 21'h1F000, 8'h00, lat, acks, bad);
    check("icd_rd_acks", 32'(acks), 32'd1);
    check("icd_rd_addr_stable", 32'(bad), 32'd0);
    check("icd_rd_data", 32'(icd_rdata), 32'hA5);

    // simultaneous CPU and ICD requests: CPU first, ICD right after CPU HOLD
    cpu_rwn = 1'b1; cpu_addr = 21'h00010; icd_rwn = 1'b1; icd_addr = 21'h1F000;
    cpu_req = 1'b1; icd_req = 1'b1;
    dk = -1; ak = -1; col = 0;
    for (int k = 0; k < 20 && ak < 0; k++) begin
      @(negedge clk6x);
      if (collide) col++;
      if (cpu_done && dk < 0) dk = k;
      if (icd_ack) ak = k;
      @(posedge clk6x); #1;
      cpu_req = 1'b0;
      if (ak >= 0) icd_req = 1'b0;
    end
    check("sim_cpu_done_k", 32'(dk), 32'd4);
    check("sim_icd_ack_k", 32'(ak), 32'd9);
    check("sim_collide_cnt", 32'(col), 32'd0);

    // cpu_req at STROBE cycle 1 of an ICD write
    icd_rwn = 1'b0; icd_addr = 21'h00ABC; icd_wdata = 8'h5E; icd_req = 1'b1;
    cpu_rwn = 1'b1; cpu_addr = 21'h00ABC;
    dk = -1; ak = -1; col = 0; colk = -1;
    for (int k = 0; k < 20 && dk < 0; k++) begin
      @(negedge clk6x);
      if (collide) begin col++; if (colk < 0) colk = k; end
      if (icd_ack) ak = k;
      if (cpu_done) dk = k;
      @(posedge clk6x); #1;
      cpu_req = (k + 1 == 2);
      if (ak >= 0) icd_req = 1'b0;
    end
    check("col_icd_ack_k", 32'(ak), 32'd4);
    check("col_cpu_done_k", 32'(dk), 32'd9);
    check("col_pulses", 32'(col), 32'd1);
    check("col_pulse_k", 32'(colk), 32'd3);
    check("col_cpu_rdata", 32'(cpu_rdata), 32'h5E);

    // second CPU request during a CPU write at the top address: pending, no collide
    cpu_rwn = 1'b0; cpu_addr = 21'h1FFFFF; cpu_wdata = 8'h3C; cpu_req = 1'b1;
    dk = -1; dk2 = -1; col = 0;
    for (int k = 0; k < 20 && dk2 < 0; k++) begin
      @(negedge clk6x);
      if (collide) col++;
      if (cpu_done) begin if (dk < 0) dk = k; else dk2 = k; end
      @(posedge clk6x); #1;
      cpu_req = (k + 1 == 2);
      if (k + 1 == 2) cpu_rwn = 1'b1;
    end
    check("pend_first_done_k", 32'(dk), 32'd4);
    check("pend_second_done_k", 32'(dk2), 32'd9);
    check("pend_collide_cnt", 32'(col), 32'd0);
    check("pend_top_addr_rdata", 32'(cpu_rdata), 32'h3C);

    // ICD blocked while cpu_window is high for 10 cycles
    icd_rwn = 1'b1; icd_addr = 21'h1F000; icd_req = 1'b1; cpu_window = 1'b1;
    cs_first = -1; cs_win = 0; ak = -1;
    for (int k = 0; k < 30 && ak < 0; k++) begin
      @(negedge clk6x);
      if (!m1csn) begin
        if (k < 10) cs_win++;
        if (cs_first < 0) cs_first = k;
      end
      if (icd_ack) ak = k;
      @(posedge clk6x); #1;
      cpu_window = (k + 1 < 10);
      if (ak >= 0) icd_req = 1'b0;
    end
    check("win_no_strobe", 32'(cs_win), 32'd0);
    check("win_first_cs_k", 32'(cs_first), 32'd11);
    check("win_icd_ack_k", 32'(ak), 32'd14);
    check("win_icd_rdata", 32'(icd_rdata), 32'hA5);

`ifdef SRAM_ARB_STATS_EN
    check("stats_icd_count", 32'(icd_count), 32'd5);
    check("stats_collide_count", 32'(collide_count), 32'd1);
`endif

    // reset during STROBE of a CPU write
    cpu_rwn = 1'b0; cpu_addr = 21'h00022; cpu_wdata = 8'h77; cpu_req = 1'b1;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk6x);
      if (cpu_done) dn++;
      if (k == 3) begin
        check("rstmid_mwrn", 32'(mwrn), 32'd1);
        check("rstmid_m1csn", 32'(m1csn), 32'd1);
        check("rstmid_mem_oe", 32'(mem_oe), 32'd0);
        check("rstmid_mem_addr", 32'(mem_addr), 32'd0);
        check("rstmid_cpu_rdata", 32'(cpu_rdata), 32'd0);
`ifdef SRAM_ARB_STATS_EN
        check("rstmid_icd_count", 32'(icd_count), 32'd0);
        check("rstmid_collide_count", 32'(collide_count), 32'd0);
`endif
      end
      @(posedge clk6x); #1;
      cpu_req = 1'b0;
      resetn = (k + 1 != 2);
    end
    check("rstmid_no_done", 32'(dn), 32'd0);

    repeat (3) @(posedge clk6x);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Owns the external SRAM strobes (M1CSn, MRDn, MWRn), the full memory address (MAH/MAL) and MD output enable.
- Shares the SRAM between two masters: the CPU bus-cycle port, which has fixed priority, and the ICD debug master, which has a req/ack handshake.
- Sequences every access as SETUP -> STROBE -> HOLD.
- Sits between the PHI2 generator / bank decoder and the SRAM pins, replacing direct CPU-driven strobes.

Parameters:
- STROBE_CYCLES, 2: clk6x cycles the strobe is held low (legal range 1..4).
- ADDR_W, 21: SRAM address width (bits 20:0).

Ports:
- clk6x  in  1  system clock.
- resetn  in  1  synchronous active-low reset.
- cpu_req  in  1  1-cycle strobe: CPU access request, already bank-translated.
- cpu_rwn  in  1  1 = read, 0 = write.
- cpu_addr  in  21  physical address.
- cpu_wdata  in  8  write data.
- cpu_rdata  out  8  read data, valid when cpu_done = 1.
- cpu_done  out  1  1-cycle completion pulse.
- cpu_window  in  1  high = CPU request may arrive within 5 cycles; ICD must not start.
- icd_req  in  1  level request; held until icd_ack.
- icd_rwn  in  1  1 = read, 0 = write.
- icd_addr  in  21  physical address.
- icd_wdata  in  8  write data.
- icd_rdata  out  8  read data, valid with icd_ack.
- icd_ack  out  1  1-cycle completion pulse.
- mem_addr  out  21  to MAH/MAL.
- mem_wdata  out  8  to MD.
- mem_oe  out  1  FPGA drives MD.
- mem_rdata  in  8  from MD.
- m1csn, mrdn, mwrn  out  1 each  SRAM strobes.
- collide  out  1  1-cycle pulse: cpu_req arrived while an ICD access was in flight.

Behaviour:
- **Reset.** resetn low at a clk6x edge puts the block in IDLE. After that edge:
  - m1csn = mrdn = mwrn = 1, mem_oe = 0.
  - cpu_done = icd_ack = collide = 0.
  - mem_addr = 0, mem_wdata = 0, rdata registers = 0.
  - Any pending CPU request is dropped and no done/ack is issued for it.
  - This applies equally when reset lands mid-access.
- **FSM states:** IDLE, SETUP, STROBE, HOLD; plus a 1-bit owner register (CPU/ICD) and a pending-CPU latch.
- **IDLE, grant rules** (checked in this order):
  1. cpu_req or pending-CPU set: grant CPU, clear pending.
  2. Else icd_req and !cpu_window: grant ICD.
  3. Otherwise stay in IDLE.
  - On grant, latch addr/rwn/wdata into mem_addr/mem_wdata and go to SETUP.
- **SETUP (1 cycle):**
  - m1csn = 0.
  - Read: mrdn = 0.
  - Write: mem_oe = 1, mwrn = 1.
- **STROBE (STROBE_CYCLES cycles, down-counter):**
  - m1csn = 0.
  - Read: mrdn = 0; mem_rdata is sampled into the owner's rdata register on the last STROBE cycle.
  - Write: mwrn = 0, mem_oe = 1.
- **HOLD (1 cycle):**
  - mrdn = mwrn = 1, m1csn = 0, mem_oe stays 1 for writes (data hold).
  - Owner's done/ack = 1.
  - Next state IDLE.
- **Latency:** grant at cycle N gives SETUP at N+1, STROBE at N+2..N+1+STROBE_CYCLES, HOLD (done/ack) at N+2+STROBE_CYCLES, IDLE at N+3+STROBE_CYCLES. Back-to-back grant is possible in that IDLE cycle.
- **Strobe glitches:** mrdn and mwrn are never both low. All strobes are registered outputs, so they are glitch-free.
- **Simultaneous cpu_req and icd_req in IDLE:** CPU wins; ICD waits, holding icd_req.
- **cpu_req during a non-IDLE state:**
  - Set pending-CPU. It is served on the next IDLE cycle, ahead of ICD.
  - If the current owner is ICD, also pulse collide.
  - A second cpu_req while pending is already set is illegal. It is ignored, and an assertion fires in simulation.
- **cpu_req during a CPU access:** same pending path, no collide.
- **rdata registers:** hold their value until the next read by the same owner.
- **Address width:** addresses are passed through unmodified, with no wrap logic; the SRAM size is handled by the bank decoder.

Optional Feature:
- Macro: SRAM_ARB_STATS_EN.
- Defined:
  - Adds outputs icd_count[15:0] and collide_count[15:0].
  - icd_count increments on each icd_ack; collide_count increments on each collide pulse.
  - Both saturate at 16'hFFFF, clear on reset, and clear together on input stats_clr (1 cycle).
  - If stats_clr coincides with an increment, the clear wins.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package nora_mem_pkg holds:
  - state encoding localparams (ST_IDLE=0, ST_SETUP=1, ST_STROBE=2, ST_HOLD=3);
  - OWNER_CPU/OWNER_ICD;
  - SRAM_ADDR_W = 21.
- One natural sub-module, sram_strobe_seq: the SETUP/STROBE/HOLD sequencer with its timing counter. sram_arbiter keeps the grant logic, pending latch, muxing and stats.

Test Plan:
- CPU write 0x0010 <- 0x12, then CPU read 0x0010:
  - mwrn low exactly 2 cycles with mem_oe = 1 from SETUP through HOLD;
  - read gives cpu_rdata = 0x12 with cpu_done at grant+4.
- ICD write 0x1F000 <- 0xA5 with cpu_window = 0, then ICD read of the same address:
  - icd_ack pulses once per access;
  - icd_rdata = 0xA5;
  - mem_addr = 0x1F000 throughout.
- cpu_req and icd_req both asserted in the same IDLE cycle:
  - CPU access completes first;
  - ICD is granted in the IDLE cycle after CPU HOLD;
  - collide = 0.
- ICD access in flight, then cpu_req at its STROBE cycle 1:
  - collide pulses;
  - CPU is granted in the IDLE cycle after ICD HOLD;
  - cpu_done arrives 5 cycles later.
- icd_req held while cpu_window = 1 for 10 cycles: no strobe activity; ICD is granted the cycle after cpu_window falls.
- resetn low during a write's STROBE state:
  - next edge gives mwrn = m1csn = 1, mem_oe = 0;
  - no cpu_done;
  - with SRAM_ARB_STATS_EN, both counters read 0.
